// File: rtl/adder_result_checker.sv
// Self-checking compare stage for a wide adder DUV against a reference.
// Ports: clk/rst/start/valid in, operands + ref + duv results in; busy/done/pass, counters, first-error capture out.
module adder_result_checker #(
  parameter int n           = 256,
  parameter int num_vectors = 30000,
  parameter int lat         = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     valid,
  input  logic                     cin,
  input  logic [n-1:0]             a,
  input  logic [n-1:0]             b,
  input  logic [n-1:0]             s_ref,
  input  logic                     cout_ref,
  input  logic [n-1:0]             s_duv,
  input  logic                     cout_duv,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [31:0]              vec_count,
  output logic [31:0]              err_count,
  output logic [31:0]              first_err_idx,
  output logic [n-1:0]             first_err_a,
  output logic [n-1:0]             first_err_b,
  output logic                     first_err_cin,
  output logic [$clog2(n+1)-1:0]   first_err_bit
);

  localparam int bw = $clog2(n + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic         v;
    logic         cin;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic [n-1:0] s;
    logic         co;
  } ent_t;

  state_t state_q, state_d;

  logic [31:0]   vec_q, err_q, idx_q;
  logic [n-1:0]  fa_q, fb_q;
  logic          fc_q;
  logic [bw-1:0] fbit_q;

  logic          run, go, cmp_en, mis;
  logic [31:0]   base_vec, base_err;
  logic [n:0]    diff;
  logic [bw-1:0] low_bit;
  ent_t          in_e, d;

  assign run = (state_q == RUN);
  // A run (re)starts from IDLE or DONE; start inside RUN is ignored.
  assign go  = start & ~run;

  assign in_e.v   = valid & (run | go);
  assign in_e.cin = cin;
  assign in_e.a   = a;
  assign in_e.b   = b;
  assign in_e.s   = s_ref;
  assign in_e.co  = cout_ref;

  generate
    if (lat == 0) begin : g_bypass
      assign d = in_e;
    end else begin : g_dl
      ent_t q [lat];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < lat; i++) q[i] <= '0;
        end else if (go) begin
          q[0] <= in_e;
          for (int i = 1; i < lat; i++) q[i] <= '0;
        end else begin
          q[0] <= in_e;
          for (int i = 1; i < lat; i++) q[i] <= q[i-1];
        end
      end
      assign d = q[lat-1];
    end
  endgenerate

  // Leftovers in the line on a restart edge belong to the old run.
  assign cmp_en = d.v & ((lat == 0) | run);

  assign diff = {cout_duv, s_duv} ^ {d.co, d.s};
  assign mis  = |diff;

  always_comb begin
    low_bit = '0;
    for (int i = n; i >= 0; i--) begin
      if (diff[i]) low_bit = bw'(i);
    end
  end

  assign base_vec = go ? 32'd0 : vec_q;
  assign base_err = go ? 32'd0 : err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     state_d = RUN;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (cmp_en && (base_vec + 32'd1 == 32'(num_vectors)))
      state_d = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q  <= '0;
      err_q  <= '0;
      idx_q  <= '0;
      fa_q   <= '0;
      fb_q   <= '0;
      fc_q   <= 1'b0;
      fbit_q <= '0;
    end else begin
      if (go) begin
        vec_q  <= '0;
        err_q  <= '0;
        idx_q  <= '0;
        fa_q   <= '0;
        fb_q   <= '0;
        fc_q   <= 1'b0;
        fbit_q <= '0;
      end
      if (cmp_en) begin
        vec_q <= base_vec + 32'd1;
        if (mis) begin
          if (base_err != '1) err_q <= base_err + 32'd1;
          else                err_q <= base_err;
          if (base_err == '0) begin
            idx_q  <= base_vec;
            fa_q   <= d.a;
            fb_q   <= d.b;
            fc_q   <= d.cin;
            fbit_q <= low_bit;
          end
        end
      end
    end
  end

  assign busy          = run;
  assign done          = (state_q == DONE);
  assign pass          = done & (err_q == '0);
  assign vec_count     = vec_q;
  assign err_count     = err_q;
  assign first_err_idx = idx_q;
  assign first_err_a   = fa_q;
  assign first_err_b   = fb_q;
  assign first_err_cin = fc_q;
  assign first_err_bit = fbit_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker: lat 0, 2 and 3 instances.
// Ref sum computed here; DUV results are ref with planted flips or delays.
module tb_adder_result_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, start = 1'b0, valid = 1'b0, cin = 1'b0;
  logic [255:0] a = '0, b = '0, s_ref = '0, s0 = '0;
  logic         cout_ref = 1'b0, c0 = 1'b0;
  logic [256:0] p [3];

  always @(posedge clk) begin
    p[2] <= p[1];
    p[1] <= p[0];
    p[0] <= {cout_ref, s_ref};
  end

  logic busy0, done0, pass0, fc0;
  logic [31:0] vc0, ec0, fi0;
  logic [255:0] fa0, fb0;
  logic [8:0] fbit0;
  logic busy3, done3, pass3, fc3;
  logic [31:0] vc3, ec3, fi3;
  logic [255:0] fa3, fb3;
  logic [8:0] fbit3;
  logic busy2, done2, pass2, fc2;
  logic [31:0] vc2, ec2, fi2;
  logic [255:0] fa2, fb2;
  logic [8:0] fbit2;

  adder_result_checker #(.n(256), .num_vectors(4), .lat(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .cin(cin),
    .a(a), .b(b), .s_ref(s_ref), .cout_ref(cout_ref),
    .s_duv(s0), .cout_duv(c0),
    .busy(busy0), .done(done0), .pass(pass0),
    .vec_count(vc0), .err_count(ec0), .first_err_idx(fi0),
    .first_err_a(fa0), .first_err_b(fb0), .first_err_cin(fc0),
    .first_err_bit(fbit0));

  adder_result_checker #(.n(256), .num_vectors(10), .lat(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .cin(cin),
    .a(a), .b(b), .s_ref(s_ref), .cout_ref(cout_ref),
    .s_duv(p[2][255:0]), .cout_duv(p[2][256]),
    .busy(busy3), .done(done3), .pass(pass3),
    .vec_count(vc3), .err_count(ec3), .first_err_idx(fi3),
    .first_err_a(fa3), .first_err_b(fb3), .first_err_cin(fc3),
    .first_err_bit(fbit3));

  adder_result_checker #(.n(256), .num_vectors(10), .lat(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .cin(cin),
    .a(a), .b(b), .s_ref(s_ref), .cout_ref(cout_ref),
    .s_duv(p[2][255:0]), .cout_duv(p[2][256]),
    .busy(busy2), .done(done2), .pass(pass2),
    .vec_count(vc2), .err_count(ec2), .first_err_idx(fi2),
    .first_err_a(fa2), .first_err_b(fb2), .first_err_cin(fc2),
    .first_err_bit(fbit2));

  int total = 0;
  int passed = 0;

  task automatic step(input logic v, input logic [255:0] ta,
                      input logic [255:0] tb_, input logic tc,
                      input int flip, input logic cflip);
    logic [256:0] r;
    valid = v;
    a = ta;
    b = tb_;
    cin = tc;
    r = {1'b0, ta} + {1'b0, tb_} + {256'd0, tc};
    s_ref = r[255:0];
    cout_ref = r[256];
    s0 = r[255:0];
    if (flip >= 0) s0[flip] = ~s0[flip];
    c0 = r[256] ^ cflip;
    @(negedge clk);
  endtask

  function automatic logic [255:0] va(input int i);
    return {8{32'h9e37_79b9 * (i + 1)}};
  endfunction

  function automatic logic [255:0] vb(input int i);
    return ({256'd0, 32'h0123_4567 ^ i} << (i * 23)) | 256'hf0f;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    step(0, '0, '0, 0, -1, 0);
    rst = 1'b0;
  endtask

  task automatic begin_run();
    start = 1'b1;
    step(0, '0, '0, 0, -1, 0);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({busy0, done0, pass0} !== 3'b000)
      $display("FAIL reset_flags got=%b want=000", {busy0, done0, pass0});
    else passed++;
    total++;
    if (vc0 !== 0 || ec0 !== 0 || fi0 !== 0 || fbit0 !== 0)
      $display("FAIL reset_counts got vc=%0d ec=%0d fi=%0d bit=%0d want 0",
               vc0, ec0, fi0, fbit0);
    else passed++;
  endtask

  task automatic test_all_pass();
    do_reset();
    begin_run();
    total++;
    if (busy0 !== 1'b1) $display("FAIL run_busy got=%b want=1", busy0);
    else passed++;
    for (int i = 0; i < 3; i++) step(1, va(i), vb(i), i[0], -1, 0);
    total++;
    if (done0 !== 1'b0 || vc0 !== 3)
      $display("FAIL pre_done got done=%b vc=%0d want 0/3", done0, vc0);
    else passed++;
    step(1, va(3), vb(3), 1, -1, 0);
    total++;
    if (done0 !== 1 || pass0 !== 1 || vc0 !== 4 || ec0 !== 0)
      $display("FAIL all_pass got d=%b p=%b vc=%0d ec=%0d want 1/1/4/0",
               done0, pass0, vc0, ec0);
    else passed++;
  endtask

  task automatic test_sum_bit();
    do_reset();
    begin_run();
    for (int i = 0; i < 4; i++)
      step(1, va(i), vb(i), 1, (i == 2) ? 17 : -1, 0);
    total++;
    if (ec0 !== 1 || fi0 !== 2 || fbit0 !== 9'd17)
      $display("FAIL sum_bit got ec=%0d idx=%0d bit=%0d want 1/2/17",
               ec0, fi0, fbit0);
    else passed++;
    total++;
    if (fa0 !== va(2) || fb0 !== vb(2) || fc0 !== 1'b1)
      $display("FAIL sum_ops got a=%h b=%h want a=%h b=%h",
               fa0, fb0, va(2), vb(2));
    else passed++;
    total++;
    if (done0 !== 1 || pass0 !== 0)
      $display("FAIL sum_verdict got d=%b p=%b want 1/0", done0, pass0);
    else passed++;
  endtask

  task automatic test_cout_only();
    do_reset();
    begin_run();
    step(1, '1, 256'd1, 0, -1, 1);
    for (int i = 1; i < 4; i++) step(1, va(i), vb(i), 0, -1, 0);
    total++;
    if (ec0 !== 1 || fbit0 !== 9'd256 || fi0 !== 0 || fa0 !== '1)
      $display("FAIL cout_only got ec=%0d bit=%0d idx=%0d want 1/256/0",
               ec0, fbit0, fi0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    step(1, va(7), vb(7), 0, -1, 0);
    start = 1'b0;
    total++;
    if (busy0 !== 1 || vc0 !== 1 || ec0 !== 0 || fbit0 !== 0)
      $display("FAIL restart got busy=%b vc=%0d ec=%0d bit=%0d want 1/1/0/0",
               busy0, vc0, ec0, fbit0);
    else passed++;
    for (int i = 0; i < 3; i++) step(1, va(i + 8), vb(i), 1, -1, 0);
    total++;
    if (done0 !== 1 || pass0 !== 1 || vc0 !== 4)
      $display("FAIL restart_done got d=%b p=%b vc=%0d want 1/1/4",
               done0, pass0, vc0);
    else passed++;
  endtask

  task automatic run_lat(input int nv);
    int k = 0;
    for (int i = 0; k < nv; i++) begin
      if (i % 3 == 2) step(0, '0, '0, 0, -1, 0);
      else begin
        step(1, va(k), vb(k), k[0], -1, 0);
        k++;
      end
    end
    for (int i = 0; i < 4; i++) step(0, '0, '0, 0, -1, 0);
  endtask

  task automatic test_latency();
    do_reset();
    begin_run();
    run_lat(10);
    total++;
    if (done3 !== 1 || pass3 !== 1 || vc3 !== 10 || ec3 !== 0)
      $display("FAIL lat3 got d=%b p=%b vc=%0d ec=%0d want 1/1/10/0",
               done3, pass3, vc3, ec3);
    else passed++;
    total++;
    if (ec2 == 0 || pass2 !== 0)
      $display("FAIL lat2 got ec=%0d pass=%b want ec>0 pass=0", ec2, pass2);
    else passed++;
  endtask

  task automatic test_abort();
    do_reset();
    begin_run();
    for (int i = 0; i < 5; i++) step(1, va(i), vb(i), 0, -1, 0);
    total++;
    if (busy3 !== 1 || vc3 !== 2)
      $display("FAIL mid_run got busy=%b vc=%0d want 1/2", busy3, vc3);
    else passed++;
    rst = 1'b1;
    step(1, va(5), vb(5), 0, -1, 0);
    rst = 1'b0;
    total++;
    if ({busy3, done3, pass3} !== 3'b000 || vc3 !== 0 || ec3 !== 0)
      $display("FAIL abort got flags=%b vc=%0d ec=%0d want 000/0/0",
               {busy3, done3, pass3}, vc3, ec3);
    else passed++;
    begin_run();
    run_lat(10);
    total++;
    if (vc3 !== 10 || pass3 !== 1)
      $display("FAIL rerun got vc=%0d pass=%b want 10/1", vc3, pass3);
    else passed++;
  endtask

  task automatic test_saturate();
    do_reset();
    begin_run();
    step(1, va(4), vb(4), 1, 5, 0);
    total++;
    if (ec0 !== 1 || fbit0 !== 9'd5)
      $display("FAIL sat_first got ec=%0d bit=%0d want 1/5", ec0, fbit0);
    else passed++;
    force dut0.err_q = 32'hffff_fffe;
    #1;
    release dut0.err_q;
    for (int i = 1; i < 4; i++) step(1, va(i), vb(i), 0, 9, 0);
    total++;
    if (ec0 !== 32'hffff_ffff)
      $display("FAIL sat_err got=%h want=ffffffff", ec0);
    else passed++;
    total++;
    if (fi0 !== 0 || fbit0 !== 9'd5 || fa0 !== va(4) || fc0 !== 1'b1)
      $display("FAIL sat_capture got idx=%0d bit=%0d cin=%b want 0/5/1",
               fi0, fbit0, fc0);
    else passed++;
    total++;
    if (done0 !== 1 || pass0 !== 0)
      $display("FAIL sat_verdict got d=%b p=%b want 1/0", done0, pass0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_sum_bit();
    test_cout_only();
    test_back_to_back();
    test_latency();
    test_abort();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adder_result_checker.md
# adder_result_checker

Synthesizable self-checking stage that sits directly downstream of the adder under verification (e.g. `csa256bits`) and the reference adder. Each cycle it compares the DUV sum/carry against the reference, counts vectors and mismatches, and captures the first failing vector. Optional latency alignment lets it check pipelined DUV variants. It ends with a single pass/fail verdict.

## Interface
Parameters:
- `n`, 256, operand/sum width
- `num_vectors`, 30000, comparisons before DONE
- `lat`, 0, DUV latency in cycles (0..8); reference side is delayed to match

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begins a run (IDLE or DONE only)
- `valid`  in  1  operands/reference valid this cycle
- `cin`  in  1  carry-in applied to both adders
- `a`, `b`  in  n  operands
- `s_ref`  in  n  reference sum
- `cout_ref`  in  1  reference carry-out
- `s_duv`  in  n  DUV sum, valid `lat` cycles after its `valid`
- `cout_duv`  in  1  DUV carry-out, same timing as `s_duv`
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE
- `pass`  out  1  `done` and `err_count`==0
- `vec_count`  out  32  comparisons performed
- `err_count`  out  32  mismatches, saturating
- `first_err_idx`  out  32  `vec_count` value at first mismatch
- `first_err_a`, `first_err_b`  out  n  operands of first mismatch
- `first_err_cin`  out  1  carry-in of first mismatch
- `first_err_bit`  out  clog2(n+1)  lowest differing bit of {cout,s}; value n = carry-out only

## Operation
- States: IDLE -> RUN on `start`; RUN -> DONE when `vec_count` reaches `num_vectors`; DONE -> RUN on `start`. `start` in RUN ignored.
- Entering RUN (from IDLE or DONE) clears counters, first-error capture and the delay line.
- Delay line: `lat`-deep shift register of {valid, cin, a, b, s_ref, cout_ref}. With `lat`=0 it is bypassed. Valid bit is forced 0 outside RUN.
- Compare when delayed valid=1 in RUN: mismatch = ({cout_duv,s_duv} != {cout_ref_d,s_ref_d}).
- Each compare increments `vec_count`. Each mismatch increments `err_count`, which saturates at 0xFFFFFFFF.
- First mismatch only (`err_count`==0 before update): latch `first_err_idx` = pre-increment `vec_count`, delayed a/b/cin, and `first_err_bit` = index of lowest set bit of the XOR.
- Compares in IDLE/DONE are discarded. Vectors still in the delay line when the count is reached are dropped.

## Timing
- Reset values: state IDLE; `busy`, `done`, `pass` 0; all counters and captures 0; delay line cleared. `rst` mid-run aborts to IDLE the same edge, with no verdict.
- Compare result is registered: counters and captures update on the edge after the aligned DUV output is presented, so there is 1 cycle of observation latency after alignment.
- `vec_count`==`num_vectors` and DONE are asserted on the same edge as the last compare. `done`/`pass` hold until `start` or `rst`.
- `start` and `rst` on the same edge: `rst` wins.
- `start` in DONE on the same edge as `valid`: that vector enters the freshly cleared delay line and is counted.
- `valid` may be deasserted any cycle (gaps allowed). Counting is by valid vectors, not cycles.

## Test plan
- n=256, lat=0, num_vectors=4, 4 vectors with s_duv=s_ref -> done=1, pass=1, vec_count=4, err_count=0 one edge after the 4th valid.
- Vector 2 (0-based) has s_duv bit 17 flipped -> err_count=1, first_err_idx=2, first_err_bit=17, first_err_a/b match vector 2, pass=0.
- Only cout_duv differs, a=all-ones, b=1, cin=0 -> first_err_bit=256, err_count=1.
- lat=3, DUV model delayed 3 cycles, 10 vectors with valid gaps -> pass=1, vec_count=10. The same run with lat=2 -> err_count>0.
- rst pulsed after 5 of 10 vectors -> next edge IDLE, all outputs 0. A new start/run of 10 completes with vec_count=10.
- Force err_count to 0xFFFFFFFE then inject 3 mismatches -> err_count holds 0xFFFFFFFF. first_err_* unchanged after the first capture.
